// File: rtl/roll_controller_if.sv
// Game I/O bundle between the roll sequencer and the rest of the bowling sim.
// slave = sequencer side, master = sim/display side.
interface roll_controller_if #(
  parameter int NUM_PINS   = 10,
  parameter int NUM_ROUNDS = 10,
  parameter int SCORE_W    = 6
);
  localparam int SCORES_W = 2*NUM_ROUNDS*SCORE_W;

  logic                start_in;
  logic                end_roll_in;
  logic [NUM_PINS-1:0] pins_hit_in;
  logic                sim_rst_out;
  logic                arm_out;
  logic [NUM_PINS-1:0] pin_mask_out;
  logic                player_no_out;
  logic                roll_no_out;
  logic [3:0]          round_no_out;
  logic [SCORES_W-1:0] score_p1_out;
  logic [SCORES_W-1:0] score_p2_out;
  logic [8:0]          total_p1_out;
  logic [8:0]          total_p2_out;
  logic                game_over_out;

  modport slave (
    input  start_in, end_roll_in, pins_hit_in,
    output sim_rst_out, arm_out, pin_mask_out, player_no_out, roll_no_out,
           round_no_out, score_p1_out, score_p2_out, total_p1_out, total_p2_out,
           game_over_out
  );

  modport master (
    output start_in, end_roll_in, pins_hit_in,
    input  sim_rst_out, arm_out, pin_mask_out, player_no_out, roll_no_out,
           round_no_out, score_p1_out, score_p2_out, total_p1_out, total_p2_out,
           game_over_out
  );
endinterface

// File: rtl/roll_controller.sv
// Two-player bowling sequencer: resets the sim, arms a roll, lets pins settle,
// tallies knocked pins into per-roll slots and advances roll/player/round.
module roll_controller #(
  parameter int NUM_PINS      = 10,
  parameter int NUM_ROUNDS    = 10,
  parameter int SCORE_W       = 6,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 2_000_000,
  parameter int ROLL_TIMEOUT  = 2**28-1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  roll_controller_if.slave  bus
);
  localparam int MAX_A   = (ROLL_TIMEOUT > SETTLE_CYCLES) ? ROLL_TIMEOUT : SETTLE_CYCLES;
  localparam int MAX_CNT = (MAX_A > RST_CYCLES) ? MAX_A : RST_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT+1);
  localparam int KW      = $clog2(NUM_PINS+1);
  localparam int SLOTS   = 2*NUM_ROUNDS;
  localparam int SLOT_W  = $clog2(SLOTS);

  typedef enum logic [2:0] {IDLE, RESET_SIM, ARM, SETTLE, TALLY, DONE} state_t;

  state_t                                state_q;
  logic [CNT_W-1:0]                      cnt_q;
  logic                                  sim_rst_q, arm_q, game_over_q;
  logic [NUM_PINS-1:0]                   mask_q;
  logic                                  player_q, roll_q;
  logic [3:0]                            round_q;
  logic [1:0][SLOTS-1:0][SCORE_W-1:0]    score_q;
  logic [1:0][8:0]                       total_q;

  logic [NUM_PINS-1:0] hit_m;
  logic [KW-1:0]       k_raw, k;
  logic                strike, last_turn;
  logic [SLOT_W-1:0]   slot_cur, slot_odd;

  // Only pins standing at the start of this roll can score.
  assign hit_m = bus.pins_hit_in & mask_q;

  always_comb begin
    k_raw = '0;
    for (int i = 0; i < NUM_PINS; i++) k_raw = k_raw + KW'(hit_m[i]);
  end

  assign k         = (k_raw > KW'(NUM_PINS)) ? KW'(NUM_PINS) : k_raw;
  assign strike    = (k == KW'(NUM_PINS));
  assign last_turn = player_q && (round_q == 4'(NUM_ROUNDS-1));
  assign slot_cur  = SLOT_W'({round_q, roll_q});
  assign slot_odd  = SLOT_W'({round_q, 1'b1});

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sim_rst_q   <= 1'b1;
      arm_q       <= 1'b0;
      game_over_q <= 1'b0;
      mask_q      <= '1;
      player_q    <= 1'b0;
      roll_q      <= 1'b0;
      round_q     <= '0;
      score_q     <= '0;
      total_q     <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start_in) begin
            state_q     <= RESET_SIM;
            cnt_q       <= '0;
            game_over_q <= 1'b0;
            mask_q      <= '1;
            player_q    <= 1'b0;
            roll_q      <= 1'b0;
            round_q     <= '0;
            score_q     <= '0;
            total_q     <= '0;
          end
        end

        RESET_SIM: begin
          if (cnt_q == CNT_W'(RST_CYCLES-1)) begin
            state_q   <= ARM;
            cnt_q     <= '0;
            sim_rst_q <= 1'b0;
            arm_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // A roll end landing on the timeout cycle still yields one transition.
        ARM: begin
          if (bus.end_roll_in || cnt_q == CNT_W'(ROLL_TIMEOUT-1)) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
            arm_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_CYCLES-1)) begin
            state_q <= TALLY;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        TALLY: begin
          cnt_q                       <= '0;
          sim_rst_q                   <= 1'b1;
          score_q[player_q][slot_cur] <= SCORE_W'(k);
          total_q[player_q]           <= total_q[player_q] + 9'(k);
          if (!roll_q && !strike) begin
            roll_q  <= 1'b1;
            mask_q  <= mask_q & ~bus.pins_hit_in;
            state_q <= RESET_SIM;
          end else begin
            if (!roll_q) score_q[player_q][slot_odd] <= '0;
            roll_q <= 1'b0;
            mask_q <= '1;
            if (last_turn) begin
              state_q     <= DONE;
              game_over_q <= 1'b1;
            end else begin
              state_q  <= RESET_SIM;
              player_q <= ~player_q;
              if (player_q) round_q <= round_q + 4'd1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sim_rst_out   = sim_rst_q;
  assign bus.arm_out       = arm_q;
  assign bus.pin_mask_out  = mask_q;
  assign bus.player_no_out = player_q;
  assign bus.roll_no_out   = roll_q;
  assign bus.round_no_out  = round_q;
  assign bus.score_p1_out  = score_q[0];
  assign bus.score_p2_out  = score_q[1];
  assign bus.total_p1_out  = total_q[0];
  assign bus.total_p2_out  = total_q[1];
  assign bus.game_over_out = game_over_q;
endmodule
